// File: rtl/mux_pkg.sv
// Shared constants for the registered 2:1 mux: width limits and select encoding.
package mux_pkg;

  localparam int unsigned MUX_WIDTH_DEFAULT = 1;
  localparam int unsigned MUX_WIDTH_MAX     = 64;

  localparam logic MUX_SEL_I0 = 1'b0;
  localparam logic MUX_SEL_I1 = 1'b1;

endpackage : mux_pkg

// File: rtl/mux_if.sv
// Data/select bundle for the registered 2:1 mux; master drives sources and select, slave returns Y.
interface mux_if #(
  parameter int unsigned WIDTH = 1
);

  logic [WIDTH-1:0] I0;
  logic [WIDTH-1:0] I1;
  logic             S;
  logic [WIDTH-1:0] Y;

  modport master (output I0, output I1, output S, input Y);
  modport slave  (input I0, input I1, input S, output Y);

endinterface : mux_if

// File: rtl/mux_sel_sync.sv
// Two-flop synchroniser for a select driven from an asynchronous domain; resets to the I0 encoding.
module mux_sel_sync
  import mux_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic sel_async,
  output logic sel_sync
);

  logic sel_meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_meta <= MUX_SEL_I0;
      sel_sync <= MUX_SEL_I0;
    end else begin
      sel_meta <= sel_async;
      sel_sync <= sel_meta;
    end
  end

endmodule : mux_sel_sync

// File: rtl/mux.sv
// Registered 2:1 data mux. Define MUX_SEL_SYNC_EN to pass S through a two-flop
// synchroniser first (select latency 3 edges instead of 1).
module mux
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = MUX_WIDTH_DEFAULT
) (
  input logic  clk,
  input logic  rst_n,
  mux_if.slave bus
);

  if ((WIDTH < 1) || (WIDTH > MUX_WIDTH_MAX)) begin : g_width_check
    $error("mux: WIDTH=%0d outside 1..%0d", WIDTH, MUX_WIDTH_MAX);
  end

  logic sel_c;

`ifdef MUX_SEL_SYNC_EN
  mux_sel_sync u_sel_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .sel_async (bus.S),
    .sel_sync  (sel_c)
  );
`else
  assign sel_c = bus.S;
`endif

  // Ternary keeps the bitwise X-merge in simulation when the select is unknown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.Y <= '0;
    end else begin
      bus.Y <= (sel_c == MUX_SEL_I1) ? bus.I1 : bus.I0;
    end
  end

endmodule : mux

// File: tb/tb_mux.sv
// Directed self-checking bench for mux: a WIDTH=1 and a WIDTH=8 instance share clk/rst_n.
module tb_mux;

`ifdef MUX_SEL_SYNC_EN
  localparam int SEL_LAT = 3;
`else
  localparam int SEL_LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  mux_if #(.WIDTH(1)) bus1 ();
  mux_if #(.WIDTH(8)) bus8 ();

  mux #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  mux #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive1(input logic i0, input logic i1, input logic s);
    bus1.I0 = i0;
    bus1.I1 = i1;
    bus1.S  = s;
  endtask

  // Basic select vectors: {I0, I1, S, expected Y}
  logic [3:0] vec [7];
  logic       s_hist [8];
  logic       s_prev;
  int         idx;

  initial begin
    vec[0] = 4'b0000; vec[1] = 4'b0100; vec[2] = 4'b1010; vec[3] = 4'b1111;
    vec[4] = 4'b0010; vec[5] = 4'b0111; vec[6] = 4'b1010;

    // Reset held with all-ones sources: Y stays 0 across edges.
    rst_n = 1'b0;
    drive1(1'b1, 1'b1, 1'b1);
    bus8.I0 = 8'hA5; bus8.I1 = 8'hFF; bus8.S = 1'b1;
    step(3);
    check("rst_hold_y1", 64'(bus1.Y), 64'd0);
    check("rst_hold_y8", 64'(bus8.Y), 64'd0);
    rst_n = 1'b1;
    #1;
    check("rst_release_pre_edge", 64'(bus1.Y), 64'd0);
    step(SEL_LAT);
    check("rst_release_y1", 64'(bus1.Y), 64'd1);
    check("rst_release_y8", 64'(bus8.Y), 64'hFF);

    // Asynchronous assertion: Y clears without a clock edge.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_y1", 64'(bus1.Y), 64'd0);
    check("rst_async_y8", 64'(bus8.Y), 64'd0);
    #2 rst_n = 1'b1;
    #1;
    check("rst_after_pulse_pre_edge", 64'(bus8.Y), 64'd0);
    repeat (SEL_LAT) @(posedge clk);
    #1;
    check("rst_midstream_recover_y8", 64'(bus8.Y), 64'hFF);
    check("rst_midstream_recover_y1", 64'(bus1.Y), 64'd1);

    // Basic select table, each vector held 4 cycles.
    step(1);
    for (int i = 0; i < 7; i++) begin
      drive1(vec[i][3], vec[i][2], vec[i][1]);
      step(4);
      check($sformatf("basic_vec%0d", i), 64'(bus1.Y), 64'(vec[i][0]));
    end

    // Data latency: I1 rises with S held high, Y follows after exactly 1 edge.
    drive1(1'b0, 1'b0, 1'b1);
    step(4);
    bus1.I1 = 1'b1;
    #1;
    check("data_lat_pre", 64'(bus1.Y), 64'd0);
    step(1);
    check("data_lat_post", 64'(bus1.Y), 64'd1);

    // Select latency: S rises with I0=0, I1=1.
    drive1(1'b0, 1'b1, 1'b0);
    step(4);
    bus1.S = 1'b1;
    for (int k = 1; k <= SEL_LAT; k++) begin
      step(1);
      check($sformatf("sel_lat_edge%0d", k), 64'(bus1.Y), (k >= SEL_LAT) ? 64'd1 : 64'd0);
    end

    // Width 8 steady selection.
    bus8.I0 = 8'hA5; bus8.I1 = 8'h3C; bus8.S = 1'b0;
    step(4);
    check("w8_s0", 64'(bus8.Y), 64'hA5);
    bus8.S = 1'b1;
    step(4);
    check("w8_s1", 64'(bus8.Y), 64'h3C);

    // Alternate S every cycle; Y follows the select driven SEL_LAT-1 cycles earlier.
    s_prev = 1'b1;
    for (int k = 0; k < 8; k++) begin
      s_hist[k] = (k % 2 == 0) ? 1'b0 : 1'b1;
      bus8.S = s_hist[k];
      step(1);
      idx = k - (SEL_LAT - 1);
      check($sformatf("w8_alt%0d", k), 64'(bus8.Y),
            (((idx < 0) ? s_prev : s_hist[idx]) != 1'b0) ? 64'h3C : 64'hA5);
    end

    // Mid-stream reset on the 8-bit instance with S=1, I1=FF.
    bus8.S = 1'b1; bus8.I1 = 8'hFF;
    step(4);
    check("w8_pre_pulse", 64'(bus8.Y), 64'hFF);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #2;
    check("w8_pulse_low", 64'(bus8.Y), 64'h00);
    #1 rst_n = 1'b1;
    repeat (SEL_LAT) @(posedge clk);
    #1;
    check("w8_post_pulse", 64'(bus8.Y), 64'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mux
